// File: rtl/shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter: direction encoding,
// log2 helper and the per-stage control payload carried beside data/shamt.
package shifter_pkg;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  function automatic int log2_ceil(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Data and shamt widths follow WIDTH, so they travel as separate vectors next to this.
  typedef struct packed {
    logic dir;
    logic arith;
    logic sign;
  } stage_ctl_t;

endpackage

// File: rtl/shift_level.sv
// One registered 2:1 mux level of the barrel shifter; the top level saturates.
// Sticky tracking is built only with SHIFT_STICKY_EN.
module shift_level
  import shifter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = 5,
  parameter int LEVEL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [WIDTH-1:0] up_data,
  input  logic [SHW-1:0]   up_shamt,
  input  stage_ctl_t       up_ctl,
`ifdef SHIFT_STICKY_EN
  input  logic             up_sticky,
  output logic             dn_sticky,
`endif
  output logic             dn_valid,
  input  logic             dn_ready,
  output logic [WIDTH-1:0] dn_data,
  output logic [SHW-1:0]   dn_shamt,
  output stage_ctl_t       dn_ctl
);

  logic             sel;
  logic             right;
  logic             fill;
  logic             valid_q;
  logic [WIDTH-1:0] nxt_data;
`ifdef SHIFT_STICKY_EN
  logic             discard;
`endif

  assign sel   = up_shamt[LEVEL];
  assign right = (up_ctl.dir == DIR_RIGHT);
  assign fill  = right & up_ctl.arith & up_ctl.sign;

  generate
    if (LEVEL == SHW - 1) begin : g_sat
      assign nxt_data = sel ? {WIDTH{fill}} : up_data;
`ifdef SHIFT_STICKY_EN
      assign discard  = sel & right & (|up_data);
`endif
    end else begin : g_shift
      localparam int S = 1 << LEVEL;
      always_comb begin
        nxt_data = up_data;
        if (sel) nxt_data = right ? {{S{fill}}, up_data[WIDTH-1:S]} : (up_data << S);
      end
`ifdef SHIFT_STICKY_EN
      assign discard = sel & right & (|up_data[S-1:0]);
`endif
    end
  endgenerate

  // A stalled stage keeps every field; it reloads only when empty or being drained.
  assign up_ready = !valid_q || dn_ready;
  assign dn_valid = valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      dn_data  <= '0;
      dn_shamt <= '0;
      dn_ctl   <= '0;
    end else if (up_ready) begin
      valid_q <= up_valid;
      if (up_valid) begin
        dn_data  <= nxt_data;
        dn_shamt <= up_shamt;
        dn_ctl   <= up_ctl;
      end
    end
  end

`ifdef SHIFT_STICKY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      dn_sticky <= 1'b0;
    end else if (up_ready && up_valid) begin
      dn_sticky <= right & (up_sticky | discard);
    end
  end
`endif

endmodule

// File: rtl/barrel_shift_pipe.sv
// Pipelined barrel shifter (left / logical right / arithmetic right, saturating).
// Define SHIFT_STICKY_EN to build the out_sticky port and sticky tracking.
module barrel_shift_pipe
  import shifter_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int SHW   = log2_ceil(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic             in_dir,
  input  logic             in_arith,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef SHIFT_STICKY_EN
  ,
  output logic             out_sticky
`endif
);

  // Index 0 is the input boundary, index k+1 is the register of level k.
  logic             valid [SHW+1];
  logic             ready [SHW+1];
  logic [WIDTH-1:0] data  [SHW+1];
  logic [SHW-1:0]   shamt [SHW+1];
  stage_ctl_t       ctl   [SHW+1];
`ifdef SHIFT_STICKY_EN
  logic             sticky [SHW+1];
  assign sticky[0]  = 1'b0;
  assign out_sticky = sticky[SHW];
`endif

  assign valid[0]     = in_valid;
  assign data[0]      = in_data;
  assign shamt[0]     = in_shamt;
  assign ctl[0].dir   = in_dir;
  assign ctl[0].arith = in_arith;
  assign ctl[0].sign  = in_data[WIDTH-1];
  assign in_ready     = ready[0];
  assign ready[SHW]   = out_ready;
  assign out_valid    = valid[SHW];
  assign out_data     = data[SHW];

  generate
    for (genvar k = 0; k < SHW; k++) begin : g_level
      shift_level #(
        .WIDTH (WIDTH),
        .SHW   (SHW),
        .LEVEL (k)
      ) u_level (
        .clk       (clk),
        .rst       (rst),
        .up_valid  (valid[k]),
        .up_ready  (ready[k]),
        .up_data   (data[k]),
        .up_shamt  (shamt[k]),
        .up_ctl    (ctl[k]),
`ifdef SHIFT_STICKY_EN
        .up_sticky (sticky[k]),
        .dn_sticky (sticky[k+1]),
`endif
        .dn_valid  (valid[k+1]),
        .dn_ready  (ready[k+1]),
        .dn_data   (data[k+1]),
        .dn_shamt  (shamt[k+1]),
        .dn_ctl    (ctl[k+1])
      );
    end
  endgenerate

endmodule

// File: tb/tb_barrel_shift_pipe.sv
// Self-checking bench for barrel_shift_pipe (WIDTH=16): directed table,
// backpressure, mid-flight reset and a random regression against a shift model.
module tb_barrel_shift_pipe;

  localparam int W  = 16;
  localparam int SW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic [SW-1:0] in_shamt = '0;
  logic          in_dir = 1'b0;
  logic          in_arith = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
`ifdef SHIFT_STICKY_EN
  logic          out_sticky;
`endif

  barrel_shift_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_dir    (in_dir),
    .in_arith  (in_arith),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef SHIFT_STICKY_EN
    ,
    .out_sticky(out_sticky)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  d;
    logic [SW-1:0] n;
    logic          dir;
    logic          arith;
    logic [W-1:0]  ed;
    logic          es;
  } vec_t;

  typedef struct {
    logic [W-1:0] d;
    logic         s;
  } exp_t;

  vec_t tbl[16];
  exp_t expq[$];
  int   n_vec = 0;
  int   n_miss = 0;
  int   acc = 0;
  logic done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] d, input logic [SW-1:0] n,
                                 input logic dir, input logic arith);
    exp_t        e;
    logic [31:0] mask;
    e.s = 1'b0;
    if (dir) begin
      e.d = (n >= W) ? '0 : (d << n);
    end else if (n >= W) begin
      e.d = (arith && d[W-1]) ? '1 : '0;
      e.s = |d;
    end else begin
      if (arith) e.d = $signed(d) >>> n;
      else       e.d = d >> n;
      mask = (32'd1 << n) - 32'd1;
      e.s  = |({16'd0, d} & mask);
    end
    return e;
  endfunction

  // Called at posedge+1; returns at posedge+1 right after the handshake edge.
  task automatic put(input logic [W-1:0] d, input logic [SW-1:0] n, input logic dir,
                     input logic arith, input exp_t e);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_shamt = n;
    in_dir   = dir;
    in_arith = arith;
    @(negedge clk);
    while (!in_ready && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      check("put_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    expq.push_back(e);
    @(posedge clk);
    #1;
    acc++;
    in_valid = 1'b0;
  endtask

  // Output monitor: in-order scoreboard plus hold-while-stalled checks.
  logic         stall_q = 1'b0;
  logic [W-1:0] stall_d = '0;
  always @(negedge clk) begin
    if (rst) begin
      stall_q = 1'b0;
    end else begin
      exp_t e;
      if (stall_q) begin
        check("stall_valid", {31'd0, out_valid}, 32'd1);
        check("stall_data", {16'd0, out_data}, {16'd0, stall_d});
      end
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          check("unexpected_out", 32'd1, 32'd0);
        end else begin
          e = expq.pop_front();
          check("out_data", {16'd0, out_data}, {16'd0, e.d});
`ifdef SHIFT_STICKY_EN
          check("out_sticky", {31'd0, out_sticky}, {31'd0, e.s});
`endif
        end
      end
      stall_q = out_valid && !out_ready;
      stall_d = out_data;
    end
  end

  task automatic drain();
    int t;
    t = 0;
    while (expq.size() != 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("drain", expq.size(), 32'd0);
  endtask

  initial begin
    tbl[0]  = '{16'h8001, 5'd1,  1'b0, 1'b0, 16'h4000, 1'b1};
    tbl[1]  = '{16'h0001, 5'd15, 1'b1, 1'b0, 16'h8000, 1'b0};
    tbl[2]  = '{16'hFFFF, 5'd16, 1'b1, 1'b0, 16'h0000, 1'b0};
    tbl[3]  = '{16'h8000, 5'd4,  1'b0, 1'b1, 16'hF800, 1'b0};
    tbl[4]  = '{16'h8000, 5'd31, 1'b0, 1'b1, 16'hFFFF, 1'b1};
    tbl[5]  = '{16'h00FF, 5'd20, 1'b0, 1'b0, 16'h0000, 1'b1};
    tbl[6]  = '{16'hA5C3, 5'd0,  1'b0, 1'b0, 16'hA5C3, 1'b0};
    tbl[7]  = '{16'hA5C3, 5'd0,  1'b0, 1'b1, 16'hA5C3, 1'b0};
    tbl[8]  = '{16'h1234, 5'd4,  1'b1, 1'b0, 16'h2340, 1'b0};
    tbl[9]  = '{16'h7F00, 5'd8,  1'b0, 1'b1, 16'h007F, 1'b0};
    tbl[10] = '{16'h8000, 5'd4,  1'b0, 1'b0, 16'h0800, 1'b0};
    tbl[11] = '{16'h8421, 5'd3,  1'b0, 1'b1, 16'hF084, 1'b1};
    tbl[12] = '{16'hA5A5, 5'd1,  1'b1, 1'b1, 16'h4B4A, 1'b0};
    tbl[13] = '{16'h0001, 5'd16, 1'b0, 1'b0, 16'h0000, 1'b1};
    tbl[14] = '{16'h7FFF, 5'd31, 1'b0, 1'b1, 16'h0000, 1'b1};
    tbl[15] = '{16'h8000, 5'd15, 1'b0, 1'b1, 16'hFFFF, 1'b0};

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {16'd0, out_data}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef SHIFT_STICKY_EN
    check("rst_out_sticky", {31'd0, out_sticky}, 32'd0);
`endif
    @(posedge clk);
    #1 out_ready = 1'b1;

    // Directed table, one beat at a time with latency measurement
    for (int i = 0; i < 16; i++) begin
      exp_t e;
      int   lat;
      e.d = tbl[i].ed;
      e.s = tbl[i].es;
      put(tbl[i].d, tbl[i].n, tbl[i].dir, tbl[i].arith, e);
      lat = 0;
      do begin
        @(negedge clk);
        lat++;
      end while (!out_valid && lat < 50);
      check("latency", lat, 32'd5);
      @(posedge clk);
      #1;
    end

    // Backpressure: 8 beats with the output stalled until the pipe fills
    @(posedge clk);
    #1 out_ready = 1'b0;
    acc = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          logic [W-1:0]  d;
          logic [SW-1:0] n;
          d = 16'h8421 ^ W'(i * 16'h1111);
          n = SW'(i * 3);
          put(d, n, i[0], i[1], model(d, n, i[0], i[1]));
        end
      end
      begin
        int t;
        t = 0;
        while (acc < 5 && t < 200) begin
          @(negedge clk);
          t++;
        end
        check("bp_accepted", acc, 32'd5);
        check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        repeat (3) begin
          @(negedge clk);
          check("bp_in_ready_hold", {31'd0, in_ready}, 32'd0);
        end
        check("bp_no_extra_accept", acc, 32'd5);
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Reset with three beats in flight
    @(posedge clk);
    #1 out_ready = 1'b0;
    for (int i = 0; i < 3; i++) put(16'h00F0 << i, SW'(i), 1'b0, 1'b0, model(16'h00F0 << i, SW'(i), 1'b0, 1'b0));
    rst = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    expq.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("postrst_no_stale", {31'd0, out_valid}, 32'd0);
    end
    check("postrst_in_ready", {31'd0, in_ready}, 32'd1);

    // Random regression with random backpressure
    @(posedge clk);
    #1;
    fork
      begin
        while (!done) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
      end
      begin
        for (int i = 0; i < 10000; i++) begin
          logic [W-1:0]  d;
          logic [SW-1:0] n;
          logic          dir;
          logic          ar;
          d   = W'($urandom());
          n   = SW'($urandom_range(0, 31));
          dir = 1'($urandom_range(0, 1));
          ar  = 1'($urandom_range(0, 1));
          if ($urandom_range(0, 4) == 0) begin
            @(posedge clk);
            #1;
          end
          put(d, n, dir, ar, model(d, n, dir, ar));
        end
        drain();
        done = 1'b1;
      end
    join

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
